rdback_drainer: RTL and testbench



---
 rtl/rdback_drainer.sv | 94 +++++++++
 tb/tb_rdback_drainer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rdback_drainer.sv
// Drains a standard (non-FWFT) readback FIFO and serialises each 4*DQ_WIDTH-bit
// word into OUT_WIDTH-bit beats, least-significant first, on a valid/ready stream.
module rdback_drainer #(
  parameter int unsigned DQ_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdback_fifo_empty,
  output logic                    rdback_fifo_rden,
  input  logic [4*DQ_WIDTH-1:0]   rdback_fifo_rddata,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [CNT_WIDTH-1:0]    words_drained
);

  localparam int unsigned WORD_W = 4 * DQ_WIDTH;
  localparam int unsigned N      = WORD_W / OUT_WIDTH;
  localparam int unsigned BW     = $clog2(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t              state, state_next;
  logic [WORD_W-1:0]   shreg, shreg_next;
  logic [BW-1:0]       beat_cnt, beat_cnt_next;
  logic [CNT_WIDTH-1:0] words_next;
  logic                beat_last;
  logic                sending;

  assign beat_last = (beat_cnt == LAST_BEAT);

  // Pop in IDLE, or prefetch on the final-beat handshake so the next word
  // lands in LOAD right after the current one finishes.
  assign rdback_fifo_rden = ~rst & ~rdback_fifo_empty &
                            ((state == IDLE) |
                             ((state == SEND) & out_ready & beat_last));

  assign sending   = (state == SEND) & ~rst;
  assign out_valid = sending;
  assign out_last  = sending & beat_last;
  assign out_data  = sending ? shreg[OUT_WIDTH-1:0] : '0;

  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    beat_cnt_next = beat_cnt;
    words_next    = words_drained;
    case (state)
      IDLE: begin
        if (rdback_fifo_rden) state_next = LOAD;
      end
      LOAD: begin
        shreg_next    = rdback_fifo_rddata;
        beat_cnt_next = '0;
        state_next    = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (!beat_last) begin
            shreg_next    = shreg >> OUT_WIDTH;
            beat_cnt_next = beat_cnt + BW'(1);
          end else begin
            words_next = words_drained + CNT_WIDTH'(1);
            state_next = rdback_fifo_rden ? LOAD : IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      beat_cnt      <= '0;
      words_drained <= '0;
    end else begin
      state         <= state_next;
      shreg         <= shreg_next;
      beat_cnt      <= beat_cnt_next;
      words_drained <= words_next;
    end
  end

endmodule

// File: tb/tb_rdback_drainer.sv
// Directed bench for rdback_drainer: FIFO model, beat scoreboard, stream-rule
// monitor and per-scenario checks on pop timing and the drained-word counter.
module tb_rdback_drainer;

  localparam int unsigned DQ_WIDTH  = 64;
  localparam int unsigned OUT_WIDTH = 32;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned N         = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  fifo_empty;
  logic                  fifo_rden;
  logic [255:0]          fifo_rddata = '0;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [CNT_WIDTH-1:0]  words_drained;

  rdback_drainer #(
    .DQ_WIDTH (DQ_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rdback_fifo_empty (fifo_empty),
    .rdback_fifo_rden  (fifo_rden),
    .rdback_fifo_rddata(fifo_rddata),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .words_drained     (words_drained)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard FIFO model: data appears the cycle after the pop.
  logic [255:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rden) begin
      fifo_rddata <= mem[rp % 64];
      rp <= rp + 1;
    end
  end

  logic [31:0] exp_q[$];
  int          acc_cyc[$];
  int          rden_cyc[$];
  logic [31:0] acc_data[$];
  int          valid_cnt = 0;
  int          beat_idx  = 0;

  task automatic push_word(input logic [255:0] w);
    mem[wp % 64] = w;
    wp = wp + 1;
    for (int j = 0; j < 8; j++) exp_q.push_back(w[j*32 +: 32]);
  endtask

  function automatic logic [255:0] mkword(input int k);
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[j*32 +: 32] = 32'hC0DE_0000 | 32'(k << 8) | 32'(j);
    return w;
  endfunction

  task automatic clear_logs();
    acc_cyc.delete();
    rden_cyc.delete();
    acc_data.delete();
    valid_cnt = 0;
  endtask

  // Monitor: stream stability, scoreboard and pop-while-empty guard.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_rden", fifo_rden, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      hold_prev = 1'b0;
    end else begin
      if (fifo_empty) check("no_pop_empty", fifo_rden, 0);
      if (fifo_rden) rden_cyc.push_back(cyc);
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid) begin
        valid_cnt++;
        if (out_ready) begin
          logic [31:0] e;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          check("beat_data", out_data, e);
          check("beat_last", out_last, (beat_idx == N - 1));
          beat_idx = (beat_idx + 1) % N;
          acc_cyc.push_back(cyc);
          acc_data.push_back(out_data);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    wp = rp;
    exp_q.delete();
    beat_idx = 0;
    rst = 1'b0;
  endtask

  initial begin
    logic [255:0] pat;
    int guard;
    pat = {4{64'h0123_4567_89AB_CDEF}};
    rst = 1'b1;
    out_ready = 1'b0;
    tick(3);
    check("reset_words", words_drained, 0);
    check("reset_valid", out_valid, 0);
    rst = 1'b0;
    tick(1);

    // Single word, ready held high
    clear_logs();
    out_ready = 1'b1;
    push_word(pat);
    tick(20);
    check("single_rden_count", rden_cyc.size(), 1);
    check("single_beats", acc_cyc.size(), 8);
    check("single_beat0", acc_data[0], 32'h89AB_CDEF);
    check("single_beat1", acc_data[1], 32'h0123_4567);
    check("single_first_latency", acc_cyc[0] - rden_cyc[0], 2);
    check("single_contiguous", acc_cyc[7] - acc_cyc[0], 7);
    check("single_words", words_drained, 1);
    check("single_idle_after", out_valid, 0);

    // Backpressure 1,0,0,1,...
    clear_logs();
    push_word(mkword(1));
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      tick(1);
    end
    out_ready = 1'b1;
    tick(2);
    check("bp_rden_count", rden_cyc.size(), 1);
    check("bp_beats", acc_cyc.size(), 8);
    check("bp_exp_empty", exp_q.size(), 0);
    check("bp_words", words_drained, 2);

    // Three words queued back-to-back
    clear_logs();
    push_word(mkword(2));
    push_word(mkword(3));
    push_word(mkword(4));
    tick(40);
    check("b2b_rden_count", rden_cyc.size(), 3);
    check("b2b_beats", acc_cyc.size(), 24);
    check("b2b_bubble1", acc_cyc[8] - acc_cyc[7], 2);
    check("b2b_bubble2", acc_cyc[16] - acc_cyc[15], 2);
    check("b2b_prefetch1", rden_cyc[1], acc_cyc[7]);
    check("b2b_prefetch2", rden_cyc[2], acc_cyc[15]);
    check("b2b_words", words_drained, 5);

    // Empty FIFO for 100 cycles
    clear_logs();
    tick(100);
    check("empty_rden_count", rden_cyc.size(), 0);
    check("empty_valid_cnt", valid_cnt, 0);
    check("empty_words", words_drained, 5);

    // Reset while beat 4 is on the bus
    clear_logs();
    push_word(mkword(5));
    guard = 0;
    while (acc_cyc.size() < 3 && guard < 50) begin
      tick(1);
      guard++;
    end
    check("rst_mid_reached", acc_cyc.size(), 3);
    check("rst_mid_valid_before", out_valid, 1);
    rst = 1'b1;
    tick(1);
    wp = rp;
    exp_q.delete();
    beat_idx = 0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_words", words_drained, 0);
    tick(1);
    clear_logs();
    push_word(mkword(6));
    tick(20);
    check("post_rst_beats", acc_cyc.size(), 8);
    check("post_rst_beat0", acc_data[0], 32'hC0DE_0600);
    check("post_rst_words", words_drained, 1);

    // Counter wrap with CNT_WIDTH=4
    do_reset();
    clear_logs();
    for (int k = 0; k < 17; k++) push_word(mkword(16 + k));
    tick(200);
    check("wrap_beats", acc_cyc.size(), 136);
    check("wrap_exp_empty", exp_q.size(), 0);
    check("wrap_words", words_drained, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
